// File: rtl/motion_alarm_controller_if.sv
// Sensor/control inputs and alarm status outputs of the motion alarm controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels sampled every cycle.
interface motion_alarm_controller_if #(
    parameter int NUM_ZONES = 4
);
    logic                 arm;
    logic                 disarm;
    logic [NUM_ZONES-1:0] zone_enable;
    logic [NUM_ZONES-1:0] motion_detected;
    logic                 armed;
    logic                 pre_alarm;
    logic                 alarm;
    logic [NUM_ZONES-1:0] alarm_zone;
    logic [1:0]           state_o;

    // Driver side: the sensor front end and the keypad
    modport master (
        output arm, disarm, zone_enable, motion_detected,
        input  armed, pre_alarm, alarm, alarm_zone, state_o
    );

    // Controller side
    modport slave (
        input  arm, disarm, zone_enable, motion_detected,
        output armed, pre_alarm, alarm, alarm_zone, state_o
    );
endinterface

// File: rtl/motion_alarm_controller.sv
// Multi-zone motion alarm: per-zone debounce, arm/disarm FSM with entry delay, instant zones, timed siren.
// Latency: a zone hit is seen on the DEBOUNCE_CYCLES-th consecutive high sample; outputs follow one edge later.
// Backpressure: none; inputs are levels sampled every cycle, outputs decode registered state only.
module motion_alarm_controller #(
    parameter int                   NUM_ZONES       = 4,
    parameter int                   DEBOUNCE_CYCLES = 3,
    parameter int                   ENTRY_DELAY     = 8,
    parameter int                   ALARM_CYCLES    = 16,
    parameter logic [NUM_ZONES-1:0] INSTANT_MASK    = NUM_ZONES'(1)
) (
    input logic                     clk,
    input logic                     reset,
    motion_alarm_controller_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EW = $clog2(ENTRY_DELAY + 1);
    localparam int AW = $clog2(ALARM_CYCLES + 1);

    localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_THR     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [EW-1:0] ENTRY_LAST = EW'(ENTRY_DELAY - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ENTRY    = 2'd2,
        ALARM    = 2'd3
    } state_t;

    state_t               state, state_nx;
    logic [EW-1:0]        entry_cnt, entry_cnt_nx;
    logic [AW-1:0]        alarm_cnt, alarm_cnt_nx;
    logic [NUM_ZONES-1:0] zone_reg, zone_nx;

    logic [DW-1:0]        db_cnt [NUM_ZONES];
    logic [NUM_ZONES-1:0] hit;
    logic                 inst_hit;
    logic                 any_hit;

    // Per-zone run-length of high samples, saturating; enable does not touch the count
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ZONES; i++) begin
            if (reset || !bus.motion_detected[i]) begin
                db_cnt[i] <= '0;
            end else if (db_cnt[i] != DB_MAX) begin
                db_cnt[i] <= db_cnt[i] + DW'(1);
            end
        end
    end

    // A hit is the D-th consecutive high sample (or later) on an enabled zone
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            hit[i] = bus.zone_enable[i] & bus.motion_detected[i] & (db_cnt[i] >= DB_THR);
        end
    end

    assign inst_hit = |(hit & INSTANT_MASK);
    assign any_hit  = |hit;

    // State, counters and the sticky zone record
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DISARMED;
            entry_cnt <= '0;
            alarm_cnt <= '0;
            zone_reg  <= '0;
        end else begin
            state     <= state_nx;
            entry_cnt <= entry_cnt_nx;
            alarm_cnt <= alarm_cnt_nx;
            zone_reg  <= zone_nx;
        end
    end

    // Next state: disarm always wins; counters are reloaded on entry so they never wrap
    always_comb begin
        state_nx     = state;
        entry_cnt_nx = '0;
        alarm_cnt_nx = '0;
        zone_nx      = zone_reg;

        unique case (state)
            DISARMED: begin
                if (bus.disarm) begin
                    zone_nx = '0;
                end else if (bus.arm) begin
                    state_nx = ARMED;
                end
            end

            ARMED: begin
                if (bus.disarm) begin
                    state_nx = DISARMED;
                    zone_nx  = '0;
                end else begin
                    zone_nx = zone_reg | hit;
                    if (inst_hit) begin
                        state_nx = ALARM;
                    end else if (any_hit) begin
                        state_nx = ENTRY;
                    end
                end
            end

            ENTRY: begin
                if (bus.disarm) begin
                    state_nx = DISARMED;
                    zone_nx  = '0;
                end else begin
                    zone_nx = zone_reg | hit;
                    if (inst_hit || entry_cnt == ENTRY_LAST) begin
                        state_nx = ALARM;
                    end else begin
                        entry_cnt_nx = entry_cnt + EW'(1);
                    end
                end
            end

            ALARM: begin
                if (bus.disarm) begin
                    state_nx = DISARMED;
                    zone_nx  = '0;
                end else begin
                    zone_nx = zone_reg | hit;
                    if (alarm_cnt == ALARM_LAST) begin
                        state_nx = ARMED;
                    end else begin
                        alarm_cnt_nx = alarm_cnt + AW'(1);
                    end
                end
            end

            default: begin
                state_nx = DISARMED;
                zone_nx  = '0;
            end
        endcase
    end

    // Outputs are pure decodes of registered state
    assign bus.armed      = (state != DISARMED);
    assign bus.pre_alarm  = (state == ENTRY);
    assign bus.alarm      = (state == ALARM);
    assign bus.alarm_zone = zone_reg;
    assign bus.state_o    = state;
endmodule
